// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data memory responder: RISC-V load/store funct3
// encodings and the responder FSM state encoding.
package data_mem_responder_pkg;

    // Load/store size encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/data_mem_responder_mem_lane_formatter.sv
// Combinational byte-lane formatter for the data memory responder.
// Ports:
//   funct3_i  : load/store size encoding
//   we_i      : 1 = store, 0 = load
//   addr_lo_i : byte lane within the word (addr[1:0])
//   rword_i   : word currently stored at the addressed index
//   wdata_i   : store data (low byte/half used for SB/SH)
//   load_o    : sign/zero-extended load value (0 on error or store)
//   wmask_o   : byte-write mask (0 on error or load)
//   wword_o   : rword_i with the masked lanes replaced by store data
//   bad_o     : illegal funct3 or misaligned access
module mem_lane_formatter
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [3:0]  wmask_o,
    output logic [31:0] wword_o,
    output logic        bad_o
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] repl_s;
    logic [31:0] bitmask_s;
    logic [31:0] load_s;
    logic [3:0]  mask_s;
    logic        bad_s;

    // Select the addressed byte/half and decode size, alignment and legality
    always_comb begin
        shifted_s = rword_i >> {addr_lo_i, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        repl_s    = wdata_i;
        load_s    = 32'd0;
        mask_s    = 4'b0000;
        bad_s     = 1'b0;
        case (funct3_i)
            F3_B: begin
                if (we_i) begin
                    mask_s = 4'b0001 << addr_lo_i;
                    repl_s = {4{wdata_i[7:0]}};
                end else begin
                    load_s = {{24{byte_s[7]}}, byte_s};
                end
            end
            F3_BU: begin
                if (we_i) begin
                    bad_s = 1'b1;
                end else begin
                    load_s = {24'd0, byte_s};
                end
            end
            F3_H: begin
                if (addr_lo_i[0]) begin
                    bad_s = 1'b1;
                end else if (we_i) begin
                    mask_s = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    repl_s = {2{wdata_i[15:0]}};
                end else begin
                    load_s = {{16{half_s[15]}}, half_s};
                end
            end
            F3_HU: begin
                if (we_i || addr_lo_i[0]) begin
                    bad_s = 1'b1;
                end else begin
                    load_s = {16'd0, half_s};
                end
            end
            F3_W: begin
                if (addr_lo_i != 2'b00) begin
                    bad_s = 1'b1;
                end else if (we_i) begin
                    mask_s = 4'b1111;
                end else begin
                    load_s = rword_i;
                end
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase
    end

    // Suppress all effects of a bad access and merge store lanes into the old word
    always_comb begin
        if (bad_s) begin
            load_o  = 32'd0;
            wmask_o = 4'b0000;
        end else begin
            load_o  = load_s;
            wmask_o = mask_s;
        end
        bitmask_s = {{8{wmask_o[3]}}, {8{wmask_o[2]}}, {8{wmask_o[1]}}, {8{wmask_o[0]}}};
        wword_o   = (rword_i & ~bitmask_s) | (repl_s & bitmask_s);
        bad_o     = bad_s;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's load/store memory interface. Accepts one
// request at a time, waits LATENCY cycles, performs a byte/half/word access
// on an internal word array and returns data or an error status.
// Ports:
//   CLK, Reset       : clock, synchronous active-low reset
//   req_*            : request channel (valid/ready, we, funct3, addr, wdata)
//   rsp_*            : response channel (valid/ready, rdata, err)
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx_s;
    logic          in_range_s;
    logic [31:0]   rword_s;
    logic          err_s;
    logic          mem_we_s;

    logic [31:0]   fmt_load_s;
    logic [3:0]    fmt_mask_s;
    logic [31:0]   fmt_wword_s;
    logic          fmt_bad_s;

    // Array index and range decode for the latched request
    always_comb begin
        idx_s      = addr_q[AW+1:2];
        in_range_s = (addr_q[31:2] < 30'(DEPTH));
        if (in_range_s) begin
            rword_s = mem_q[idx_s];
        end else begin
            rword_s = 32'd0;
        end
        err_s = fmt_bad_s | ~in_range_s;
    end

    mem_lane_formatter u_fmt (
        .funct3_i  (f3_q),
        .we_i      (we_q),
        .addr_lo_i (addr_q[1:0]),
        .rword_i   (rword_s),
        .wdata_i   (wdata_q),
        .load_o    (fmt_load_s),
        .wmask_o   (fmt_mask_s),
        .wword_o   (fmt_wword_s),
        .bad_o     (fmt_bad_s)
    );

    // FSM next-state: accept in IDLE, count wait states, access, hold response
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY);
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counter reaching zero marks the access edge, so the response
                // appears LATENCY+1 edges after the accept edge.
                if (cnt_q == '0) begin
                    mem_we_s    = we_q & ~err_s;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_s;
                    rsp_rdata_d = (err_s | we_q) ? 32'd0 : fmt_load_s;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and response registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array write port; contents survive reset and a reset drops a pending store
    always_ff @(posedge CLK) begin
        if (Reset && mem_we_s && (fmt_mask_s != 4'b0000)) begin
            mem_q[idx_s] <= fmt_wword_s;
        end
    end

    assign req_ready = (state_q == ST_IDLE) & Reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid_s [2];
    logic        req_ready_s [2];
    logic        req_we_s    [2];
    logic [2:0]  req_f3_s    [2];
    logic [31:0] req_addr_s  [2];
    logic [31:0] req_wdata_s [2];
    logic        rsp_valid_s [2];
    logic        rsp_ready_s [2];
    logic [31:0] rsp_rdata_s [2];
    logic        rsp_err_s   [2];

    int checks_r;
    int errors_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: default LATENCY=2; instance 1: LATENCY=0
    data_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .CLK(clk), .Reset(rst_n),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
        .req_we(req_we_s[0]), .req_funct3(req_f3_s[0]),
        .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
        .rsp_rdata(rsp_rdata_s[0]), .rsp_err(rsp_err_s[0])
    );

    data_mem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
        .CLK(clk), .Reset(rst_n),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
        .req_we(req_we_s[1]), .req_funct3(req_f3_s[1]),
        .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
        .rsp_rdata(rsp_rdata_s[1]), .rsp_err(rsp_err_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; returns response and edges from accept to rsp_valid
    task automatic xact(input int sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready_s[sel] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        req_valid_s[sel] = 1'b1;
        req_we_s[sel]    = we;
        req_f3_s[sel]    = f3;
        req_addr_s[sel]  = addr;
        req_wdata_s[sel] = wdata;
        @(posedge clk); #1;
        req_valid_s[sel] = 1'b0;
        lat = 0;
        while (!rsp_valid_s[sel] && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid_s[sel]) chk("rsp_timeout", 32'd0, 32'd1);
        rdata = rsp_rdata_s[sel];
        err   = rsp_err_s[sel];
        rsp_ready_s[sel] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_s[sel] = 1'b0;
    endtask

    // Transaction plus check of data and error flag
    task automatic acc(input string tag, input int sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic        e;
        int          l;
        xact(sel, we, f3, addr, wdata, d, e, l);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] held;
        logic        e;
        int          l;
        checks_r = 0;
        errors_r = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid_s[i] = 1'b0; req_we_s[i] = 1'b0; req_f3_s[i] = 3'b000;
            req_addr_s[i] = 32'd0; req_wdata_s[i] = 32'd0; rsp_ready_s[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid_s[0]}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_s[0]}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_s[0], 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err_s[0]}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_req_ready", {31'd0, req_ready_s[0]}, 32'd1);

        // Test 1: reset during WAIT drops the pending store
        acc("t1_pre_sw", 0, 1'b1, 3'b010, 32'h10, 32'h55667788, 32'd0, 1'b0);
        req_valid_s[0] = 1'b1; req_we_s[0] = 1'b1; req_f3_s[0] = 3'b010;
        req_addr_s[0] = 32'h10; req_wdata_s[0] = 32'h11223344;
        @(posedge clk); #1;
        req_valid_s[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t1_rst_rsp_valid", {31'd0, rsp_valid_s[0]}, 32'd0);
        chk("t1_rst_req_ready", {31'd0, req_ready_s[0]}, 32'd0);
        @(posedge clk); #1;
        chk("t1_rst2_rsp_valid", {31'd0, rsp_valid_s[0]}, 32'd0);
        rst_n = 1'b1;
        acc("t1_lw", 0, 1'b0, 3'b010, 32'h10, 32'd0, 32'h55667788, 1'b0);

        // Test 2: store latency and readback
        xact(0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, d, e, l);
        chk("t2_sw_latency", l, 32'd3);
        chk("t2_sw_rdata", d, 32'd0);
        chk("t2_sw_err", {31'd0, e}, 32'd0);
        xact(0, 1'b0, 3'b010, 32'h20, 32'd0, d, e, l);
        chk("t2_lw_latency", l, 32'd3);
        chk("t2_lw_data", d, 32'hDEADBEEF);

        // Test 3: byte store and sub-word loads
        acc("t3_sb", 0, 1'b1, 3'b000, 32'h21, 32'h000000AA, 32'd0, 1'b0);
        acc("t3_lw", 0, 1'b0, 3'b010, 32'h20, 32'd0, 32'hDEADAAEF, 1'b0);
        acc("t3_lb", 0, 1'b0, 3'b000, 32'h21, 32'd0, 32'hFFFFFFAA, 1'b0);
        acc("t3_lbu", 0, 1'b0, 3'b100, 32'h21, 32'd0, 32'h000000AA, 1'b0);
        acc("t3_lhu", 0, 1'b0, 3'b101, 32'h22, 32'd0, 32'h0000DEAD, 1'b0);
        acc("t3_lh", 0, 1'b0, 3'b001, 32'h22, 32'd0, 32'hFFFFDEAD, 1'b0);
        acc("t3_sh", 0, 1'b1, 3'b001, 32'h22, 32'h00001234, 32'd0, 1'b0);
        acc("t3_lw2", 0, 1'b0, 3'b010, 32'h20, 32'd0, 32'h1234AAEF, 1'b0);

        // Test 4: error cases leave the array unchanged
        acc("t4_lw_mis", 0, 1'b0, 3'b010, 32'h22, 32'd0, 32'd0, 1'b1);
        acc("t4_sh_mis", 0, 1'b1, 3'b001, 32'h23, 32'h0000FFFF, 32'd0, 1'b1);
        acc("t4_f3_011", 0, 1'b0, 3'b011, 32'h20, 32'd0, 32'd0, 1'b1);
        acc("t4_lw_oor", 0, 1'b0, 3'b010, 32'd4096, 32'd0, 32'd0, 1'b1);
        acc("t4_sbu_st", 0, 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'd0, 1'b1);
        acc("t4_sw_mis", 0, 1'b1, 3'b010, 32'h21, 32'hFFFFFFFF, 32'd0, 1'b1);
        acc("t4_lw_chk", 0, 1'b0, 3'b010, 32'h20, 32'd0, 32'h1234AAEF, 1'b0);

        // Test 5: response backpressure and ignored request
        req_valid_s[0] = 1'b1; req_we_s[0] = 1'b0; req_f3_s[0] = 3'b010;
        req_addr_s[0] = 32'h20; req_wdata_s[0] = 32'd0;
        @(posedge clk); #1;
        req_valid_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_rsp_valid", {31'd0, rsp_valid_s[0]}, 32'd1);
        held = rsp_rdata_s[0];
        chk("t5_rdata", held, 32'h1234AAEF);
        req_valid_s[0] = 1'b1; req_addr_s[0] = 32'h10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", {31'd0, rsp_valid_s[0]}, 32'd1);
            chk("t5_hold_rdata", rsp_rdata_s[0], 32'h1234AAEF);
            chk("t5_hold_ready", {31'd0, req_ready_s[0]}, 32'd0);
        end
        rsp_ready_s[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_s[0] = 1'b0;
        chk("t5_idle_valid", {31'd0, rsp_valid_s[0]}, 32'd0);
        chk("t5_idle_ready", {31'd0, req_ready_s[0]}, 32'd1);
        @(posedge clk); #1;
        req_valid_s[0] = 1'b0;
        chk("t5_accept_ready", {31'd0, req_ready_s[0]}, 32'd0);
        l = 0;
        while (!rsp_valid_s[0] && l < 20) begin
            @(posedge clk); #1; l++;
        end
        chk("t5_second_lat", l, 32'd3);
        chk("t5_second_data", rsp_rdata_s[0], 32'h55667788);
        rsp_ready_s[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_s[0] = 1'b0;

        // Test 6: zero wait states
        xact(1, 1'b1, 3'b010, 32'h0, 32'h00000001, d, e, l);
        chk("t6_sw_latency", l, 32'd1);
        chk("t6_sw_err", {31'd0, e}, 32'd0);
        xact(1, 1'b0, 3'b010, 32'h0, 32'd0, d, e, l);
        chk("t6_lw_latency", l, 32'd1);
        chk("t6_lw_data", d, 32'h00000001);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
